mix_columns_seq: RTL and testbench
==================================

# mix_columns_seq

Sequential, parametrised AES MixColumns/InvMixColumns engine for the AES datapath, the handshaked successor to the combinational `MixColumns` stage. It accepts one 128-bit state per transaction over a valid/ready interface and processes `COLS_PER_CYCLE` columns per clock. This trades area against latency for the DE10 round pipeline. It returns the transformed state on a held valid/ready output, with direction selected per transaction.

## Interface
- `COLS_PER_CYCLE`, default 1: GF(2^8) column units instantiated. Legal values are 1, 2, 4; any other value is an elaboration error.
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRst_n`  in  1  reset, asynchronous and active-low.
- `iData`  in  128  input state. Column c = bits [127-32c -: 32]. Row 0 of each column is its MSB byte.
- `iInv`  in  1  0 = MixColumns, 1 = InvMixColumns. Sampled only at input handshake.
- `iValid`  in  1  input state valid.
- `oReady`  out  1  engine can accept a state.
- `oData`  out  128  result state, same byte order as `iData`.
- `oValid`  out  1  result valid.
- `iReady`  in  1  downstream accepts the result.

## Operation
- N = 4 / COLS_PER_CYCLE passes per state.
- Registers:
  - 128-bit input buffer
  - 128-bit result buffer
  - latched mode bit
  - 2-bit column counter `col`
  - state machine IDLE / BUSY / DONE
- **IDLE:**
  - `oReady`=1.
  - On `iValid`&`oReady`: capture `iData` and `iInv`, clear `col`, go to BUSY.
- **BUSY:**
  - Each cycle, columns `col` .. `col+COLS_PER_CYCLE-1` of the input buffer pass through the column units and are written to the same positions in the result buffer.
  - `col` advances by `COLS_PER_CYCLE`.
  - After the pass covering column 3, go to DONE. `col` wraps to 0.
- **DONE:**
  - `oValid`=1 and `oData` = result buffer, held stable until `iReady`=1.
  - On `oValid`&`iReady`: go to IDLE.
- `iValid` in BUSY or DONE is ignored. `oReady`=0, so no capture occurs.
- `iData` and `iInv` changes after capture have no effect on the transaction in flight.
- Column arithmetic, bytes a0..a3 of one column, xtime = shift left 1 with conditional XOR 0x1B:
  - Forward: b_r = 2·a_r ⊕ 3·a_{r+1} ⊕ a_{r+2} ⊕ a_{r+3}, indices mod 4.
  - Inverse: b_r = 0E·a_r ⊕ 0B·a_{r+1} ⊕ 0D·a_{r+2} ⊕ 09·a_{r+3}.
  - Purely combinational inside each unit; every product is reduced to 8 bits.
- **Reset, asserted at any time including mid-BUSY:**
  - Immediately IDLE, `col`=0, mode=0.
  - Buffers and `oData` = 0, `oValid`=0.
  - `oReady` goes to 1 only after reset deasserts.
  - A partially processed state is discarded.

## Timing
- Accept at edge T → `oValid`=1 after edge T+N: 4 cycles for C=1, 2 for C=2, 1 for C=4.
- `oReady` falls at edge T, and rises again the cycle after the output handshake edge.
- Back-to-back throughput with `iReady` tied high: one state per N+2 cycles.
- `oReady`, `oValid` and `oData` are registered or state-decoded only; there is no combinational path from `iValid` or `iReady`.

## Configuration
- **`MIXCOL_INV_EN` defined:**
  - Each column unit contains both forward and inverse datapaths, muxed by the latched mode bit.
- **`MIXCOL_INV_EN` undefined:**
  - Inverse logic is not compiled.
  - `iInv` is ignored, the mode register is absent, and every transaction is forward MixColumns.
  - Timing is identical in both builds.

## Test plan
- **Forward vector:** C=1 and C=4, `iData`=8233ea63fcac161bee28c3c4c193f54b, `iInv`=0 → `oData`=c3a2db82019e5193b8240c5189b37ea8, `oValid` after exactly 4 and 1 cycles respectively.
- **FIPS-197 columns:** `iData`=db135345f20a225c01010101c6c6c6c6, forward → 8e4da1bc9fdc589d01010101c6c6c6c6; all C values.
- **Inverse round-trip (`MIXCOL_INV_EN`):**
  - `iData`=c3a2db82019e5193b8240c5189b37ea8, `iInv`=1 → 8233ea63fcac161bee28c3c4c193f54b.
  - Same input with the macro undefined → forward result of that input.
- **Backpressure:** hold `iReady`=0 for 10 cycles in DONE → `oData` stable, `oValid`=1, `oReady`=0.
  - Toggling `iValid` and `iData` during this window does not alter the result.
- **Mid-operation reset:**
  - Pulse `iRst_n` low during BUSY cycle 2 (C=1) → `oValid`=0 and `oData`=0 at once, `oReady`=1 after release.
  - The next transaction (all-zero state) → 0.
- **Back-to-back:** three states with `iReady`=1 (C=2) → results in order, handshakes spaced exactly 4 cycles apart.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: valid/ready bundle carrying one 128-bit AES state in and one out.
// master drives the input state and result acceptance; slave is the engine side.
interface mix_columns_seq_if;
    logic [127:0] iData;
    logic         iInv;
    logic         iValid;
    logic         oReady;
    logic [127:0] oData;
    logic         oValid;
    logic         iReady;

    modport master (
        output iData, iInv, iValid, iReady,
        input  oReady, oData, oValid
    );

    modport slave (
        input  iData, iInv, iValid, iReady,
        output oReady, oData, oValid
    );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns engine, COLS_PER_CYCLE column units per clock.
// Define MIXCOL_INV_EN to add InvMixColumns, selected per transaction by iInv.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    mix_columns_seq_if.slave bus
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic [1:0]  col_q;
    logic [31:0] in_col_q  [4];
    logic [31:0] res_col_q [4];
    logic [31:0] unit_out  [COLS_PER_CYCLE];
    logic        capture;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // 2*a_r ^ 3*a_{r+1} folded as xt(a_r ^ a_{r+1}) ^ a_{r+1}
    function automatic logic [31:0] fwd_col(input logic [31:0] a);
        logic [7:0]  v [4];
        logic [31:0] b;
        b = '0;
        for (int unsigned r = 0; r < 4; r++) v[2'(r)] = a[31-8*r -: 8];
        for (int unsigned r = 0; r < 4; r++)
            b[31-8*r -: 8] = xt(v[2'(r)] ^ v[2'(r+1)]) ^ v[2'(r+1)] ^ v[2'(r+2)] ^ v[2'(r+3)];
        return b;
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic logic [31:0] inv_col(input logic [31:0] a);
        logic [7:0]  v [4];
        logic [7:0]  m9 [4], mb [4], md [4], me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] b;
        b = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            v[2'(r)]  = a[31-8*r -: 8];
            x2        = xt(v[2'(r)]);
            x4        = xt(x2);
            x8        = xt(x4);
            m9[2'(r)] = x8 ^ v[2'(r)];
            mb[2'(r)] = x8 ^ x2 ^ v[2'(r)];
            md[2'(r)] = x8 ^ x4 ^ v[2'(r)];
            me[2'(r)] = x8 ^ x4 ^ x2;
        end
        for (int unsigned r = 0; r < 4; r++)
            b[31-8*r -: 8] = me[2'(r)] ^ mb[2'(r+1)] ^ md[2'(r+2)] ^ m9[2'(r+3)];
        return b;
    endfunction

    logic mode_q;
`else
    logic unused_inv;
    assign unused_inv = bus.iInv;
`endif

    assign capture    = (state_q == IDLE) && ready_q && bus.iValid;
    assign bus.oReady = ready_q;
    assign bus.oValid = (state_q == DONE);
    assign bus.oData  = {res_col_q[0], res_col_q[1], res_col_q[2], res_col_q[3]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = BUSY;
            BUSY:    if (col_q == LAST_COL) state_d = DONE;
            DONE:    if (bus.iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready is registered so it stays low while reset is held and rises on the first edge after
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        for (int unsigned u = 0; u < COLS_PER_CYCLE; u++) begin
`ifdef MIXCOL_INV_EN
            unit_out[u] = mode_q ? inv_col(in_col_q[col_q + 2'(u)])
                                 : fwd_col(in_col_q[col_q + 2'(u)]);
`else
            unit_out[u] = fwd_col(in_col_q[col_q + 2'(u)]);
`endif
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            col_q <= '0;
`ifdef MIXCOL_INV_EN
            mode_q <= 1'b0;
`endif
            for (int unsigned c = 0; c < 4; c++) begin
                in_col_q[2'(c)]  <= '0;
                res_col_q[2'(c)] <= '0;
            end
        end else if (capture) begin
            col_q <= '0;
`ifdef MIXCOL_INV_EN
            mode_q <= bus.iInv;
`endif
            for (int unsigned c = 0; c < 4; c++) in_col_q[2'(c)] <= bus.iData[127-32*c -: 32];
        end else if (state_q == BUSY) begin
            col_q <= col_q + COL_STEP;
            for (int unsigned u = 0; u < COLS_PER_CYCLE; u++) res_col_q[col_q + 2'(u)] <= unit_out[u];
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: runs C=1, C=2 and C=4 engines side by side against a
// GF(2^8) matrix reference model; honours MIXCOL_INV_EN like the design.
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] tb_data = '0;
    logic         tb_inv = 1'b0;
    logic [2:0]   tb_valid = '0;
    logic [2:0]   tb_ready = '0;
    logic [2:0]   o_valid, o_ready;
    logic [127:0] o_data [3];
    int           lat_exp [3] = '{4, 2, 1};
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    mix_columns_seq_if if0 ();
    mix_columns_seq_if if1 ();
    mix_columns_seq_if if2 ();

    assign if0.iData = tb_data;  assign if0.iInv = tb_inv;
    assign if1.iData = tb_data;  assign if1.iInv = tb_inv;
    assign if2.iData = tb_data;  assign if2.iInv = tb_inv;
    assign if0.iValid = tb_valid[0]; assign if0.iReady = tb_ready[0];
    assign if1.iValid = tb_valid[1]; assign if1.iReady = tb_ready[1];
    assign if2.iValid = tb_valid[2]; assign if2.iReady = tb_ready[2];
    assign o_valid = {if2.oValid, if1.oValid, if0.oValid};
    assign o_ready = {if2.oReady, if1.oReady, if0.oReady};
    assign o_data[0] = if0.oData;
    assign o_data[1] = if1.oData;
    assign o_data[2] = if2.oData;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.iClk(clk), .iRst_n(rst_n), .bus(if0));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.iClk(clk), .iRst_n(rst_n), .bus(if1));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.iClk(clk), .iRst_n(rst_n), .bus(if2));

    // carry-less product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc ^= (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (acc[i]) acc ^= (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic inv_in);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        logic         inv;
        inv = inv_in;
`ifndef MIXCOL_INV_EN
        inv = 1'b0;
`endif
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(coef[k], d[127 - 32*c - 8*((r + k) % 4) -: 8]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        return res;
    endfunction

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // accept on all masked engines, measure latency, check data, then hand the result off
    task automatic run_txn(input logic [2:0] mask, input logic [127:0] d, input logic inv,
                           input logic [127:0] exp, input string tag);
        int         lat [3];
        logic [2:0] seen;
        tb_data = d; tb_inv = inv; tb_valid = mask; tb_ready = '0;
        chk_int({tag, " ready before"}, int'(o_ready & mask), int'(mask));
        @(posedge clk); #1;
        tb_valid = '0; tb_data = ~d; tb_inv = ~inv;
        chk_int({tag, " ready drop"}, int'(o_ready & mask), 0);
        seen = '0;
        lat = '{-1, -1, -1};
        for (int k = 0; k <= 12; k++) begin
            for (int i = 0; i < 3; i++)
                if (mask[i] && !seen[i] && o_valid[i]) begin
                    seen[i] = 1'b1;
                    lat[i] = k;
                end
            if ((seen & mask) == mask) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++)
            if (mask[i]) begin
                chk_int($sformatf("%s latency c%0d", tag, i), lat[i], lat_exp[i]);
                chk128($sformatf("%s data c%0d", tag, i), o_data[i], exp);
            end
        tb_ready = mask;
        @(posedge clk); #1;
        tb_ready = '0;
        chk_int({tag, " valid clear"}, int'(o_valid & mask), 0);
        chk_int({tag, " ready back"}, int'(o_ready & mask), int'(mask));
    endtask

    typedef struct {
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t         vecs [5];
    logic [127:0] d, e;
    logic [127:0] ins [3];
    logic [127:0] outs [$];
    int           acc_t [$];
    int           out_t [$];
    logic         in_hs, out_hs;
    logic [127:0] cap;
    int           n_in;

    initial begin
        vecs[0] = '{128'h8233ea63fcac161bee28c3c4c193f54b, 1'b0,
                    128'hc3a2db82019e5193b8240c5189b37ea8, "fwd vector"};
        vecs[1] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
                    128'h8e4da1bc9fdc589d01010101c6c6c6c6, "fips cols"};
`ifdef MIXCOL_INV_EN
        vecs[2] = '{128'hc3a2db82019e5193b8240c5189b37ea8, 1'b1,
                    128'h8233ea63fcac161bee28c3c4c193f54b, "inverse"};
`else
        vecs[2] = '{128'hc3a2db82019e5193b8240c5189b37ea8, 1'b1,
                    ref_mix(128'hc3a2db82019e5193b8240c5189b37ea8, 1'b0), "inv ignored"};
`endif
        vecs[3] = '{'0, 1'b0, '0, "zero"};
        vecs[4] = '{{4{32'hffffffff}}, 1'b0, {4{32'hffffffff}}, "all ones"};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_int("reset ready", int'(o_ready), 0);
        chk_int("reset valid", int'(o_valid), 0);
        for (int i = 0; i < 3; i++) chk128($sformatf("reset data c%0d", i), o_data[i], '0);
        rst_n = 1'b1;
        #1;
        chk_int("ready held after release", int'(o_ready), 0);
        @(posedge clk); #1;
        chk_int("ready after release", int'(o_ready), 7);

        foreach (vecs[v]) run_txn(3'b111, vecs[v].data, vecs[v].inv, vecs[v].exp, vecs[v].name);

        for (int n = 0; n < 20; n++) begin
            d = rnd128();
            tb_inv = 1'($urandom);
            run_txn(3'b111, d, tb_inv, ref_mix(d, tb_inv), $sformatf("rand%0d", n));
        end

        // backpressure: results must hold while inputs churn
        d = rnd128();
        e = ref_mix(d, 1'b0);
        tb_data = d; tb_inv = 1'b0; tb_valid = 3'b111; tb_ready = '0;
        @(posedge clk); #1;
        tb_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            tb_valid = 3'($urandom);
            tb_data = rnd128();
            tb_inv = 1'($urandom);
            @(posedge clk); #1;
            chk_int($sformatf("bp valid %0d", k), int'(o_valid), 7);
            chk_int($sformatf("bp ready %0d", k), int'(o_ready), 0);
            for (int i = 0; i < 3; i++) chk128($sformatf("bp data %0d c%0d", k, i), o_data[i], e);
        end
        tb_valid = '0; tb_ready = 3'b111;
        @(posedge clk); #1;
        tb_ready = '0;
        chk_int("bp released", int'(o_valid), 0);

        // reset during the second BUSY cycle of the C=1 engine
        tb_data = rnd128(); tb_valid = 3'b111;
        @(posedge clk); #1;
        tb_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_int("midrst valid", int'(o_valid), 0);
        chk_int("midrst ready", int'(o_ready), 0);
        for (int i = 0; i < 3; i++) chk128($sformatf("midrst data c%0d", i), o_data[i], '0);
        repeat (2) @(posedge clk);
        #1;
        chk_int("midrst ready held", int'(o_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_int("midrst ready after", int'(o_ready), 7);
        run_txn(3'b111, '0, 1'b0, '0, "post reset zero");

        // back-to-back on the C=2 engine with the sink always ready
        for (int i = 0; i < 3; i++) ins[i] = rnd128();
        n_in = 0;
        tb_inv = 1'b0; tb_data = ins[0]; tb_valid = 3'b010; tb_ready = 3'b010;
        for (int cyc = 0; cyc < 40 && outs.size() < 3; cyc++) begin
            in_hs = tb_valid[1] & o_ready[1];
            out_hs = o_valid[1] & tb_ready[1];
            cap = o_data[1];
            @(posedge clk); #1;
            if (in_hs) begin
                acc_t.push_back(cyc);
                n_in++;
                if (n_in < 3) tb_data = ins[n_in];
                else tb_valid = '0;
            end
            if (out_hs) begin
                outs.push_back(cap);
                out_t.push_back(cyc);
            end
        end
        tb_valid = '0; tb_ready = '0;
        chk_int("b2b accepts", acc_t.size(), 3);
        chk_int("b2b results", outs.size(), 3);
        foreach (outs[i]) chk128($sformatf("b2b data %0d", i), outs[i], ref_mix(ins[i], 1'b0));
        if (acc_t.size() == 3) begin
            chk_int("b2b in spacing 1", acc_t[1] - acc_t[0], 4);
            chk_int("b2b in spacing 2", acc_t[2] - acc_t[1], 4);
        end
        if (out_t.size() == 3) begin
            chk_int("b2b out spacing 1", out_t[1] - out_t[0], 4);
            chk_int("b2b out spacing 2", out_t[2] - out_t[1], 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
